// File: rtl/decoder_lut_pkg.sv
// Shared definitions for the decoder/LUT logic unit: mode codes,
// FSM states and the preset truth-table builder.
package decoder_lut_pkg;

  localparam logic [2:0] MODE_NAND = 3'b000;
  localparam logic [2:0] MODE_NOR  = 3'b001;
  localparam logic [2:0] MODE_AND  = 3'b010;
  localparam logic [2:0] MODE_OR   = 3'b011;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;
  localparam logic [2:0] MODE_RSVD = 3'b110;
  localparam logic [2:0] MODE_LOAD = 3'b111;

  typedef enum logic {
    RUN,
    LOAD
  } state_t;

  function automatic logic is_preset(input logic [2:0] mode);
    return mode <= MODE_XNOR;
  endfunction

  // Bit i of the table is the function value for minterm i;
  // bits at or above 2**n_in stay zero.
  function automatic logic [15:0] preset_table(
    input logic [2:0] mode,
    input int         n_in
  );
    logic [15:0] t;
    logic [3:0]  m;
    logic [3:0]  full;
    t    = '0;
    full = 4'((1 << n_in) - 1);
    for (int i = 0; i < 16; i++) begin
      m = 4'(i);
      if (i < (1 << n_in)) begin
        case (mode)
          MODE_NAND: t[i] = (m != full);
          MODE_NOR:  t[i] = (m == 4'd0);
          MODE_AND:  t[i] = (m == full);
          MODE_OR:   t[i] = (m != 4'd0);
          MODE_XOR:  t[i] = ^m;
          MODE_XNOR: t[i] = ~^m;
          default:   t[i] = 1'b0;
        endcase
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/decoder_lut_unit_onehot.sv
// Combinational binary-to-one-hot decoder.
module onehot_decoder #(
  parameter  int N_IN = 2,
  localparam int N_MT = 2 ** N_IN
) (
  input  logic [N_IN-1:0] sel,
  output logic [N_MT-1:0] dec
);

  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_lut_unit.sv
// Two-stage decoder + truth-table logic unit with preset/custom tables.
// Optional table readback: define DECODER_LUT_READBACK_EN.
module decoder_lut_unit
  import decoder_lut_pkg::*;
#(
  parameter  int N_IN = 2,
  localparam int N_MT = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic [2:0]      cfg_mode,
  input  logic            lut_valid,
  input  logic            lut_bit,
  output logic            cfg_busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  output logic            out_y,
  output logic [N_MT-1:0] out_dec
`ifdef DECODER_LUT_READBACK_EN
  ,
  output logic [N_MT-1:0] lut_rd,
  output logic            cfg_done
`endif
);

  localparam logic [N_IN-1:0] LAST = N_IN'(N_MT - 1);

  state_t          state;
  logic [N_MT-1:0] lut;
  logic [N_MT-1:0] shadow;
  logic [N_MT-1:0] sh_next;
  logic [N_MT-1:0] dec;
  logic [N_MT-1:0] dec_q;
  logic [N_IN-1:0] cnt;
  logic            v1;
  logic            accept;
  logic            preset;
  logic            load_go;
  logic            beat;
  logic            last;

  assign in_ready = (state == RUN);
  assign cfg_busy = (state == LOAD);
  assign accept   = in_valid && in_ready;
  assign preset   = in_ready && cfg_start && is_preset(cfg_mode);
  assign load_go  = in_ready && cfg_start && (cfg_mode == MODE_LOAD);
  assign beat     = cfg_busy && lut_valid;
  assign last     = beat && (cnt == LAST);

  onehot_decoder #(
    .N_IN(N_IN)
  ) u_dec (
    .sel(in_data),
    .dec(dec)
  );

  // The final beat is merged here so lut gets the whole table at once.
  always_comb begin
    sh_next      = shadow;
    sh_next[cnt] = lut_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      lut       <= N_MT'(preset_table(MODE_NAND, N_IN));
      shadow    <= '0;
      cnt       <= '0;
      v1        <= 1'b0;
      dec_q     <= '0;
      out_valid <= 1'b0;
      out_dec   <= '0;
      out_y     <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) dec_q <= dec;
      out_valid <= v1;
      if (v1) begin
        out_y   <= |(dec_q & lut);
        out_dec <= dec_q;
      end
      unique case (state)
        RUN: begin
          if (load_go) begin
            state  <= LOAD;
            cnt    <= '0;
            shadow <= '0;
          end else if (preset) begin
            lut <= N_MT'(preset_table(cfg_mode, N_IN));
          end
        end
        LOAD: begin
          if (beat) begin
            shadow <= sh_next;
            cnt    <= cnt + 1'b1;
            if (last) begin
              lut   <= sh_next;
              state <= RUN;
            end
          end
        end
      endcase
    end
  end

`ifdef DECODER_LUT_READBACK_EN
  assign lut_rd = lut;

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_done <= 1'b0;
    else        cfg_done <= preset || last;
  end
`endif

endmodule

// File: tb/tb_decoder_lut_unit.sv
// Scoreboard bench for decoder_lut_unit, N_IN=2 and N_IN=4 instances,
// checked against a popcount-based truth-table model.
module tb_decoder_lut_unit;

  typedef struct {
    logic        y;
    logic [15:0] dec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_start, a_lv, a_lb, a_busy, a_iv, a_ir, a_ov, a_y;
  logic [2:0]  a_mode;
  logic [1:0]  a_data;
  logic [3:0]  a_dec;
  logic        b_start, b_lv, b_lb, b_busy, b_iv, b_ir, b_ov, b_y;
  logic [2:0]  b_mode;
  logic [3:0]  b_data;
  logic [15:0] b_dec;
`ifdef DECODER_LUT_READBACK_EN
  logic [3:0]  a_rd;
  logic        a_done;
  logic [15:0] b_rd;
  logic        b_done;
`endif

  decoder_lut_unit #(.N_IN(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(a_start), .cfg_mode(a_mode),
    .lut_valid(a_lv), .lut_bit(a_lb), .cfg_busy(a_busy),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_data),
    .out_valid(a_ov), .out_y(a_y), .out_dec(a_dec)
`ifdef DECODER_LUT_READBACK_EN
    , .lut_rd(a_rd), .cfg_done(a_done)
`endif
  );

  decoder_lut_unit #(.N_IN(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(b_start), .cfg_mode(b_mode),
    .lut_valid(b_lv), .lut_bit(b_lb), .cfg_busy(b_busy),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_data),
    .out_valid(b_ov), .out_y(b_y), .out_dec(b_dec)
`ifdef DECODER_LUT_READBACK_EN
    , .lut_rd(b_rd), .cfg_done(b_done)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  exp_t qa[$];
  exp_t qb[$];

  int   nin[2] = '{2, 4};
  bit   tbl[2][16];
  bit   sh[2][16];
  bit   mload[2];
  int   cnt[2];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Function value from the count of true inputs among n.
  function automatic bit fbit(input int mode, input int n, input int m);
    int pc;
    pc = $countones(m);
    case (mode)
      0:       return pc != n;
      1:       return pc == 0;
      2:       return pc == n;
      3:       return pc != 0;
      4:       return (pc % 2) == 1;
      default: return (pc % 2) == 0;
    endcase
  endfunction

  function automatic logic [15:0] packed_tbl(input int w);
    logic [15:0] p;
    p = '0;
    for (int m = 0; m < (1 << nin[w]); m++) p[m] = tbl[w][m];
    return p;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && a_ov) begin
      if (qa.size() == 0) begin
        check("a_unexpected_out", 16'd1, 16'd0);
      end else begin
        e = qa.pop_front();
        check("a_out_y", 16'(a_y), 16'(e.y));
        check("a_out_dec", 16'(a_dec), e.dec);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_ov) begin
      if (qb.size() == 0) begin
        check("b_unexpected_out", 16'd1, 16'd0);
      end else begin
        e = qb.pop_front();
        check("b_out_y", 16'(b_y), 16'(e.y));
        check("b_out_dec", b_dec, e.dec);
      end
    end
  end

  task automatic step(input int w, input bit st, input int md,
                      input bit iv, input int d, input bit lv, input bit lb);
    int   nmt;
    bit   upd;
    exp_t e;
    nmt = 1 << nin[w];
    upd = 1'b0;
    if (w == 0) begin
      a_start = st; a_mode = 3'(md); a_iv = iv;
      a_data = 2'(d); a_lv = lv; a_lb = lb;
      check("a_in_ready", 16'(a_ir), 16'(!mload[0]));
      check("a_cfg_busy", 16'(a_busy), 16'(mload[0]));
    end else begin
      b_start = st; b_mode = 3'(md); b_iv = iv;
      b_data = 4'(d); b_lv = lv; b_lb = lb;
      check("b_in_ready", 16'(b_ir), 16'(!mload[1]));
      check("b_cfg_busy", 16'(b_busy), 16'(mload[1]));
    end
    if (st && !mload[w] && md <= 5) begin
      for (int m = 0; m < nmt; m++) tbl[w][m] = fbit(md, nin[w], m);
      upd = 1'b1;
    end
    if (iv && !mload[w]) begin
      e.y   = tbl[w][d];
      e.dec = 16'(1) << d;
      if (w == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    if (!mload[w] && st && md == 7) begin
      mload[w] = 1'b1;
      cnt[w]   = 0;
    end else if (mload[w] && lv) begin
      sh[w][cnt[w]] = lb;
      if (cnt[w] == nmt - 1) begin
        for (int m = 0; m < nmt; m++) tbl[w][m] = sh[w][m];
        mload[w] = 1'b0;
        upd      = 1'b1;
      end else begin
        cnt[w]++;
      end
    end
    @(posedge clk);
    #1;
`ifdef DECODER_LUT_READBACK_EN
    if (w == 0) begin
      check("a_cfg_done", 16'(a_done), 16'(upd));
      check("a_lut_rd", 16'(a_rd), packed_tbl(0));
    end else begin
      check("b_cfg_done", 16'(b_done), 16'(upd));
      check("b_lut_rd", b_rd, packed_tbl(1));
    end
`endif
  endtask

  task automatic idle(input int w, input int n);
    for (int i = 0; i < n; i++) step(w, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_start = 0; a_mode = 0; a_lv = 0; a_lb = 0; a_iv = 0; a_data = 0;
    b_start = 0; b_mode = 0; b_lv = 0; b_lb = 0; b_iv = 0; b_data = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    for (int w = 0; w < 2; w++) begin
      mload[w] = 1'b0;
      cnt[w]   = 0;
      for (int m = 0; m < 16; m++) begin
        tbl[w][m] = (m < (1 << nin[w])) ? fbit(0, nin[w], m) : 1'b0;
        sh[w][m]  = 1'b0;
      end
    end
    check("rst_a_out_valid", 16'(a_ov), 16'd0);
    check("rst_a_out_y", 16'(a_y), 16'd0);
    check("rst_a_out_dec", 16'(a_dec), 16'd0);
    check("rst_b_out_valid", 16'(b_ov), 16'd0);
    check("rst_b_out_dec", b_dec, 16'd0);
`ifdef DECODER_LUT_READBACK_EN
    check("rst_a_lut_rd", 16'(a_rd), 16'h0007);
    check("rst_b_lut_rd", b_rd, 16'h7fff);
`endif
  endtask

  initial begin
    do_reset();
    check("rst_a_in_ready", 16'(a_ir), 16'd1);
    check("rst_a_cfg_busy", 16'(a_busy), 16'd0);

    // Default NAND table on all four minterms back to back.
    for (int d = 0; d < 4; d++) step(0, 0, 0, 1, d, 0, 0);
    idle(0, 3);

    // XOR preset together with an operand in the same cycle.
    step(0, 1, 4, 1, 3, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(0, 3);

    // Custom load 0,1,1,0 with operands offered while busy.
    step(0, 1, 7, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 2, 1, 1, 1, 1);
    step(0, 0, 0, 1, 2, 1, 1);
    step(0, 0, 0, 1, 3, 1, 0);
    for (int d = 0; d < 4; d++) step(0, 0, 0, 1, d, 0, 0);
    idle(0, 3);

    // Reset in the middle of a load, then a full load is needed.
    step(0, 1, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    do_reset();
    for (int d = 0; d < 4; d++) step(0, 0, 0, 1, d, 0, 0);
    step(0, 1, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    for (int d = 0; d < 4; d++) step(0, 0, 0, 1, d, 0, 0);
    idle(0, 3);

    // Random traffic including reserved codes and stray beats.
    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    idle(0, 3);

    // Wide instance: NOR preset, exhaustive operands.
    step(1, 1, 1, 0, 0, 0, 0);
    for (int d = 0; d < 16; d++) step(1, 0, 0, 1, d, 0, 0);
    idle(1, 3);
    for (int i = 0; i < 400; i++)
      step(1, $urandom_range(0, 15) == 0, $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 15),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    idle(1, 4);

    check("a_queue_drained", 16'(qa.size()), 16'd0);
    check("b_queue_drained", 16'(qb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
